// File: rtl/mem_bus_arbiter.sv
// Three-master arbiter for a single shared memory port: registered one-hot grant,
// latched request payload, 4-phase handshake per transaction and a response watchdog.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned POLICY  = 0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            mode,
    input  logic [3*ADDR_W-1:0]   locator,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            grant,
    output logic [2:0]            resp,
    output logic                  mem_request,
    output logic                  mem_mode,
    output logic [ADDR_W-1:0]     mem_locator,
    output logic [DATA_W-1:0]     mem_write,
    input  logic                  mem_response,
    output logic                  timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit WDOG_EN = (TIMEOUT != 0);
    localparam bit RR_EN   = (POLICY == 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] wdog;

    logic [1:0] win;
    logic [1:0] base;
    logic [1:0] idx;
    logic       owner_req;
    logic [1:0] next_ptr;

    // (a + b) mod 3 for a, b in 0..2
    function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Scan from the highest-priority slot last so it overrides lower-priority hits
    always_comb begin
        win  = 2'd0;
        idx  = 2'd0;
        base = RR_EN ? ptr : 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = wrap_add(base, 2'(k));
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    assign owner_req = |(req & grant);
    assign next_ptr  = grant[2] ? 2'd0 : (grant[1] ? 2'd2 : 2'd1);

    // grant is only cleared in RELEASE, so resp cannot reach a non-owner
    assign resp = {3{mem_response}} & grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 3'b000;
            mem_request <= 1'b0;
            mem_mode    <= 1'b0;
            mem_locator <= '0;
            mem_write   <= '0;
            timeout_err <= 1'b0;
            ptr         <= 2'd0;
            wdog        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog <= '0;
                    if (|req) begin
                        grant       <= 3'b001 << win;
                        mem_mode    <= mode[win];
                        mem_request <= 1'b1;
                        state       <= ACCESS;
                        case (win)
                            2'd1: begin
                                mem_locator <= locator[ADDR_W +: ADDR_W];
                                mem_write   <= wdata[DATA_W +: DATA_W];
                            end
                            2'd2: begin
                                mem_locator <= locator[2*ADDR_W +: ADDR_W];
                                mem_write   <= wdata[2*DATA_W +: DATA_W];
                            end
                            default: begin
                                mem_locator <= locator[0 +: ADDR_W];
                                mem_write   <= wdata[0 +: DATA_W];
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    if (mem_response) begin
                        wdog  <= '0;
                        state <= HOLD;
                    end else if (!owner_req) begin
                        mem_request <= 1'b0;
                        state       <= RELEASE;
                    end else if (WDOG_EN && (wdog == CNT_LAST)) begin
                        timeout_err <= 1'b1;
                        mem_request <= 1'b0;
                        state       <= RELEASE;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!owner_req) begin
                        mem_request <= 1'b0;
                        state       <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!mem_response) begin
                        grant <= 3'b000;
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
